serial_to_parallel_receiver: RTL and testbench



---
 rtl/serial_to_parallel_receiver.sv | 64 ++++++
 tb/tb_serial_to_parallel_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_receiver.sv
// serial_to_parallel_receiver: reassembles MSB-first serial frames into parallel words
module serial_to_parallel_receiver #(
  parameter int WIDTH = 8,
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               input_bit,
  input  logic               bit_valid,
  input  logic               frame_start,
  output logic [WIDTH-1:0]   parallel_out,
  output logic               word_valid,
  output logic               busy,
  output logic               frame_error,
  output logic [COUNT_W-1:0] frame_count
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, RECEIVE} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0] cnt;
  assign shifted = (shreg << 1) | WIDTH'(input_bit);
  assign busy = (state == RECEIVE);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      parallel_out <= '0;
      word_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_error <= 1'b0;
      if (bit_valid && frame_start) begin
        // a one-bit frame is complete the moment its start bit arrives
        if (WIDTH == 1) begin
          parallel_out <= WIDTH'(input_bit);
          word_valid <= 1'b1;
          frame_count <= frame_count + COUNT_W'(1);
          state <= IDLE;
        end else begin
          frame_error <= (state == RECEIVE);
          shreg <= WIDTH'(input_bit);
          cnt <= CW'(1);
          state <= RECEIVE;
        end
      end else if (bit_valid && state == RECEIVE) begin
        if (cnt == CW'(WIDTH - 1)) begin
          parallel_out <= shifted;
          word_valid <= 1'b1;
          frame_count <= frame_count + COUNT_W'(1);
          cnt <= '0;
          state <= IDLE;
        end else begin
          shreg <= shifted;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// tb_serial_to_parallel_receiver: directed frames checked against a bit-queue model every cycle
module tb_serial_to_parallel_receiver;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic input_bit = 1'b0;
  logic bit_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [7:0] po;
  logic wv, bsy, fe;
  logic [7:0] fc;
  logic [7:0] po2;
  logic wv2, bsy2, fe2;
  logic [1:0] fc2;
  logic [0:0] po1;
  logic wv1, bsy1, fe1;
  logic [7:0] fc1;
  int vectors = 0;
  int miscompares = 0;
  bit en = 1'b0;
  int q[$];
  logic [7:0] e_po = '0;
  bit e_wv = 0, e_fe = 0;
  int e_cnt = 0;
  bit e1_po = 0, e1_wv = 0;
  int e1_cnt = 0;

  serial_to_parallel_receiver #(.WIDTH(8), .COUNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .input_bit(input_bit), .bit_valid(bit_valid),
    .frame_start(frame_start), .parallel_out(po), .word_valid(wv), .busy(bsy),
    .frame_error(fe), .frame_count(fc));
  serial_to_parallel_receiver #(.WIDTH(8), .COUNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .input_bit(input_bit), .bit_valid(bit_valid),
    .frame_start(frame_start), .parallel_out(po2), .word_valid(wv2), .busy(bsy2),
    .frame_error(fe2), .frame_count(fc2));
  serial_to_parallel_receiver #(.WIDTH(1), .COUNT_W(8)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .input_bit(input_bit), .bit_valid(bit_valid),
    .frame_start(frame_start), .parallel_out(po1), .word_valid(wv1), .busy(bsy1),
    .frame_error(fe1), .frame_count(fc1));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_po = '0; e_wv = 0; e_fe = 0; e_cnt = 0;
    e1_po = 0; e1_wv = 0; e1_cnt = 0;
  endtask

  // frame content is the ordered list of sampled bits; the first one is the MSB
  task automatic model_step();
    logic [7:0] w;
    if (!RST_N) begin
      model_reset();
      return;
    end
    e_wv = 0; e_fe = 0; e1_wv = 0;
    if (bit_valid) begin
      if (frame_start) begin
        if (q.size() > 0) e_fe = 1;
        q.delete();
        q.push_back(int'(input_bit));
        e1_wv = 1; e1_po = input_bit; e1_cnt++;
      end else if (q.size() > 0) q.push_back(int'(input_bit));
      if (q.size() == 8) begin
        w = 0;
        foreach (q[i]) w = w * 2 + 8'(q[i]);
        e_po = w; e_wv = 1; e_cnt++;
        q.delete();
      end
    end
  endtask

  task automatic drive(input logic bv, input logic fs, input logic b);
    @(posedge CLK);
    model_step();
    #1;
    bit_valid = bv; frame_start = fs; input_bit = b;
  endtask

  task automatic send_frame(input logic [7:0] w, input int stall_at, input int stall_n);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) repeat (stall_n) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, i == 0, w[7-i]);
    end
  endtask

  always @(negedge CLK) begin
    if (en) begin
      chk("po", int'(po), int'(e_po));
      chk("word_valid", int'(wv), int'(e_wv));
      chk("frame_error", int'(fe), int'(e_fe));
      chk("busy", int'(bsy), int'(q.size() > 0));
      chk("frame_count", int'(fc), e_cnt % 256);
      chk("cw2_frame_count", int'(fc2), e_cnt % 4);
      chk("w1_po", int'(po1), int'(e1_po));
      chk("w1_word_valid", int'(wv1), int'(e1_wv));
      chk("w1_frame_count", int'(fc1), e1_cnt % 256);
      chk("w1_busy_fe", int'({bsy1, fe1}), 0);
      chk("wv_fe_exclusive", int'(wv & fe), 0);
    end
  end

  initial begin
    #2 RST_N = 1'b0;
    model_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("reset_po", int'(po), 0);
    chk("reset_fc", int'(fc), 0);
    chk("reset_busy", int'(bsy), 0);
    @(negedge CLK); #2 RST_N = 1'b1;
    en = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    send_frame(8'hC0, -1, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_c0_po", int'(po), 8'hC0);
    chk("lit_c0_wv", int'(wv), 1);
    chk("lit_c0_fc", int'(fc), 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_c0_wv_drop", int'(wv), 0);
    send_frame(8'hA5, 4, 3);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_a5_po", int'(po), 8'hA5);
    chk("lit_a5_fc", int'(fc), 2);
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    chk("lit_abort_busy", int'(bsy), 1);
    drive(1'b1, 1'b0, 1'b0);
    chk("lit_abort_fe", int'(fe), 1);
    chk("lit_abort_po_held", int'(po), 8'hA5);
    for (int i = 2; i < 8; i++) drive(1'b1, 1'b0, 8'h3C >> (7 - i));
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_3c_po", int'(po), 8'h3C);
    chk("lit_3c_fc", int'(fc), 3);
    send_frame(8'h01, -1, 0);
    send_frame(8'h02, -1, 0);
    chk("lit_b2b_po01", int'(po), 8'h01);
    send_frame(8'h03, -1, 0);
    chk("lit_b2b_po02", int'(po), 8'h02);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_b2b_po03", int'(po), 8'h03);
    chk("lit_b2b_fc", int'(fc), 6);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("lit_async_po", int'(po), 0);
    chk("lit_async_fc", int'(fc), 0);
    chk("lit_async_busy", int'(bsy), 0);
    chk("lit_async_wv_fe", int'({wv, fe}), 0);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge CLK); #2 RST_N = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
    send_frame(8'h07, -1, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_07_po", int'(po), 8'h07);
    chk("lit_07_fc", int'(fc), 1);
    chk("lit_cw2_1", int'(fc2), 1);
    send_frame(8'h11, -1, 0);
    send_frame(8'h22, -1, 0);
    send_frame(8'h33, -1, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_cw2_wrap0", int'(fc2), 0);
    send_frame(8'h44, -1, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("lit_cw2_1_again", int'(fc2), 1);
    chk("lit_fc5", int'(fc), 5);
    chk("lit_w1_fc", int'(fc1), 5);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
